ahbl_sram16_ctrl: RTL and testbench



---
 rtl/ahbl_sram16_ctrl.sv | 141 ++++++++++++++
 tb/tb_ahbl_sram16_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram16_ctrl.sv
// AHB-Lite slave onto 16-bit async SRAM; words split into two halfword cycles, all pins registered.
// Data phase: read 1 (narrow) / 2 (word) cycles, write 3 / 5 cycles; stalls the bus via hready_resp.
module ahbl_sram16_ctrl #(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int W_SRAM_ADDR = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ahbls_hready,
    output logic                   ahbls_hready_resp,
    output logic                   ahbls_hresp,
    input  logic [W_ADDR-1:0]      ahbls_haddr,
    input  logic                   ahbls_hwrite,
    input  logic [1:0]             ahbls_htrans,
    input  logic [2:0]             ahbls_hsize,
    input  logic [2:0]             ahbls_hburst,
    input  logic [3:0]             ahbls_hprot,
    input  logic                   ahbls_hmastlock,
    input  logic [W_DATA-1:0]      ahbls_hwdata,
    output logic [W_DATA-1:0]      ahbls_hrdata,
    output logic [W_SRAM_ADDR-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_ce_n,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WSETUP,
        S_WSTROBE,
        S_WHOLD
    } state_t;

    state_t                 state;
    logic                   hi_pending;
    logic                   lane_hi;
    logic                   narrow_rd;
    logic [15:0]            rdata_lo;

    logic                   accept;
    logic                   acc_word;
    logic                   acc_byte;
    logic                   at_resp;
    logic [W_SRAM_ADDR-1:0] acc_addr;

    logic unused_ok;
    assign unused_ok = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_htrans[0],
                         ahbls_hsize[2], ahbls_haddr[W_ADDR-1:W_SRAM_ADDR+1]};

    assign accept   = ahbls_hready && ahbls_htrans[1];
    assign acc_word = ahbls_hsize[1];
    assign acc_byte = (ahbls_hsize[1:0] == 2'b00);
    assign acc_addr = acc_word ? {ahbls_haddr[W_SRAM_ADDR:2], 1'b0} : ahbls_haddr[W_SRAM_ADDR:1];

    // Last data-phase cycle (or idle): the only points where a new address phase is taken.
    assign at_resp = (state == S_IDLE) ||
                     (!hi_pending && (state == S_READ || state == S_WHOLD));

    assign ahbls_hresp  = 1'b0;
    assign ahbls_hrdata = narrow_rd ? {sram_dq_in, sram_dq_in} : {sram_dq_in, rdata_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            hi_pending        <= 1'b0;
            lane_hi           <= 1'b0;
            narrow_rd         <= 1'b1;
            rdata_lo          <= 16'h0000;
            ahbls_hready_resp <= 1'b1;
            sram_addr         <= '0;
            sram_dq_out       <= 16'h0000;
            sram_dq_oe        <= 1'b0;
            sram_ce_n         <= 1'b1;
            sram_we_n         <= 1'b1;
            sram_oe_n         <= 1'b1;
            sram_ub_n         <= 1'b1;
            sram_lb_n         <= 1'b1;
        end else if (at_resp) begin
            if (accept) begin
                state             <= ahbls_hwrite ? S_WSETUP : S_READ;
                hi_pending        <= acc_word;
                lane_hi           <= ahbls_haddr[1] && !acc_word;
                narrow_rd         <= !acc_word;
                ahbls_hready_resp <= !ahbls_hwrite && !acc_word;
                sram_addr         <= acc_addr;
                sram_dq_oe        <= 1'b0;
                sram_ce_n         <= 1'b0;
                sram_we_n         <= 1'b1;
                sram_oe_n         <= ahbls_hwrite;
                sram_lb_n         <= acc_byte && ahbls_haddr[0];
                sram_ub_n         <= acc_byte && !ahbls_haddr[0];
            end else begin
                state             <= S_IDLE;
                ahbls_hready_resp <= 1'b1;
                sram_dq_oe        <= 1'b0;
                sram_ce_n         <= 1'b1;
                sram_we_n         <= 1'b1;
                sram_oe_n         <= 1'b1;
                sram_ub_n         <= 1'b1;
                sram_lb_n         <= 1'b1;
            end
        end else begin
            case (state)
                S_READ: begin
                    // Low half is on the pads now; keep it and move to the high half.
                    rdata_lo          <= sram_dq_in;
                    sram_addr[0]      <= 1'b1;
                    hi_pending        <= 1'b0;
                    ahbls_hready_resp <= 1'b1;
                end
                S_WSETUP: begin
                    sram_dq_out <= lane_hi ? ahbls_hwdata[31:16] : ahbls_hwdata[15:0];
                    sram_dq_oe  <= 1'b1;
                    sram_we_n   <= 1'b0;
                    state       <= S_WSTROBE;
                end
                S_WSTROBE: begin
                    sram_we_n         <= 1'b1;
                    ahbls_hready_resp <= !hi_pending;
                    state             <= S_WHOLD;
                end
                S_WHOLD: begin
                    sram_addr[0] <= 1'b1;
                    sram_dq_out  <= ahbls_hwdata[31:16];
                    sram_we_n    <= 1'b0;
                    hi_pending   <= 1'b0;
                    state        <= S_WSTROBE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_sram16_ctrl.sv
// Bench for ahbl_sram16_ctrl: pipelined AHB master, halfword SRAM model, byte-level reference memory.
module tb_ahbl_sram16_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        hready;
    logic        hready_resp;
    logic        hresp;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;

    always #5 clk = ~clk;
    assign hready = hready_resp;

    ahbl_sram16_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .ahbls_hready      (hready),
        .ahbls_hready_resp (hready_resp),
        .ahbls_hresp       (hresp),
        .ahbls_haddr       (haddr),
        .ahbls_hwrite      (hwrite),
        .ahbls_htrans      (htrans),
        .ahbls_hsize       (hsize),
        .ahbls_hburst      (hburst),
        .ahbls_hprot       (hprot),
        .ahbls_hmastlock   (hmastlock),
        .ahbls_hwdata      (hwdata),
        .ahbls_hrdata      (hrdata),
        .sram_addr         (sram_addr),
        .sram_dq_out       (sram_dq_out),
        .sram_dq_oe        (sram_dq_oe),
        .sram_dq_in        (sram_dq_in),
        .sram_ce_n         (sram_ce_n),
        .sram_we_n         (sram_we_n),
        .sram_oe_n         (sram_oe_n),
        .sram_ub_n         (sram_ub_n),
        .sram_lb_n         (sram_lb_n)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic [15:0] mem  [0:255];
    logic [7:0]  refm [0:511];
    xfer_t       pend [$];
    logic [31:0] exp_q[$];
    xfer_t       a_cur, dp_cur;
    logic        dp_vld;
    int          dp_len, n_chk, n_bad, n_we, tot;
    logic [17:0] last_wa;
    logic        last_ub, last_lb;
    logic [15:0] last_dq;

    // Pads only drive read data while the SRAM is selected and output-enabled.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0BAD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_len(input xfer_t x);
        if (x.wr) return (x.size == 3'd2) ? 5 : 3;
        return (x.size == 3'd2) ? 2 : 1;
    endfunction

    task automatic sram_tick();
        if (!rst && !sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  = sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] = sram_dq_out[15:8];
            n_we++;
            last_wa = sram_addr;
            last_ub = sram_ub_n;
            last_lb = sram_lb_n;
            last_dq = sram_dq_out;
            chk("wr_pads", 32'({sram_dq_oe, sram_oe_n}), 32'h3);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sram_tick();
    endtask

    task automatic enq(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.wr = wr; x.size = sz; x.addr = a; x.wdata = d;
        pend.push_back(x);
        tot += exp_len(x);
    endtask

    task automatic present(input xfer_t x);
        int a, b;
        a = int'(x.addr[8:0]);
        htrans = 2'b10;
        hwrite = x.wr;
        hsize  = x.size;
        haddr  = 32'h2000_0000 | x.addr;
        if (x.wr) begin
            if (x.size == 3'd2) begin
                b = a & ~3;
                for (int i = 0; i < 4; i++) refm[b + i] = x.wdata[8*i +: 8];
            end else if (x.size == 3'd1) begin
                b = a & ~1;
                for (int i = 0; i < 2; i++) refm[b + i] = x.wdata[16*(a/2%2) + 8*i +: 8];
            end else begin
                refm[a] = x.wdata[8*(a%4) +: 8];
            end
        end else begin
            if (x.size == 3'd2) begin
                b = a & ~3;
                exp_q.push_back({refm[b+3], refm[b+2], refm[b+1], refm[b]});
            end else begin
                b = a & ~1;
                exp_q.push_back({refm[b+1], refm[b], refm[b+1], refm[b]});
            end
        end
    endtask

    task automatic step();
        logic done;
        tick();
        done = hready_resp;
        if (dp_vld) dp_len++;
        if (done && dp_vld) begin
            chk("dlen", 32'(dp_len), 32'(exp_len(dp_cur)));
            if (!dp_cur.wr) begin
                chk("sb_depth", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) chk("rdata", hrdata, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (done) begin
            dp_vld = htrans[1];
            dp_cur = a_cur;
            dp_len = 0;
            hwdata = a_cur.wdata;
            if (pend.size() > 0) begin
                a_cur = pend.pop_front();
                present(a_cur);
            end else begin
                htrans = 2'b00;
            end
        end
    endtask

    task automatic run(input int budget, output int n);
        n = 0;
        while ((pend.size() > 0 || dp_vld || htrans[1]) && n < budget) begin
            step();
            n++;
        end
        chk("timeout", 32'(n < budget), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0;
        logic seen;
        rst = 1'b1;
        haddr = 32'h0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'd0;
        hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hwdata = 32'h0;
        dp_vld = 1'b0; dp_len = 0; n_chk = 0; n_bad = 0; n_we = 0; tot = 0;
        a_cur.wr = 1'b0; a_cur.size = 3'd0; a_cur.addr = 32'h0; a_cur.wdata = 32'h0;
        dp_cur = a_cur;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'hA5C3;
        mem[1] = 16'h1234;
        for (int i = 0; i < 256; i++) begin
            refm[2*i]   = mem[i][7:0];
            refm[2*i+1] = mem[i][15:8];
        end

        // Reset values
        repeat (2) tick();
        chk("rst_hready", 32'(hready_resp), 32'h1);
        chk("rst_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'h1F);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
        chk("hresp", 32'(hresp), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // IDLE / BUSY only
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 htrans = i[0] ? 2'b01 : 2'b00;
            haddr = 32'h2000_0000 + 32'(i * 4);
            tick();
            chk("idle_pins", 32'({hready_resp, sram_ce_n, sram_we_n, sram_oe_n,
                                  sram_ub_n, sram_lb_n, sram_dq_oe}), 32'h7E);
        end
        @(posedge clk);
        #1 htrans = 2'b00;

        // Word write then word read
        enq(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        enq(1'b0, 3'd2, 32'h10, 32'h0);
        run(100, n);
        chk("mem8", 32'(mem[8]), 32'hBEEF);
        chk("mem9", 32'(mem[9]), 32'hDEAD);

        // Halfword read of SRAM[1]
        enq(1'b0, 3'd1, 32'h2, 32'h0);
        run(100, n);

        // Byte write to upper byte of halfword 1, then check neighbours unchanged
        n0 = n_we;
        enq(1'b1, 3'd0, 32'h3, 32'h5A5A5A5A);
        run(100, n);
        chk("byte_we_count", 32'(n_we - n0), 32'h1);
        chk("byte_addr", 32'(last_wa), 32'h1);
        chk("byte_ub_lb", 32'({last_ub, last_lb}), 32'h1);
        chk("byte_dq", 32'(last_dq), 32'h5A5A);
        chk("byte_mem1", 32'(mem[1]), 32'h5A34);
        enq(1'b0, 3'd2, 32'h0, 32'h0);
        run(100, n);

        // Back-to-back pipelined mix, no idle cycles in between
        tot = 0;
        enq(1'b0, 3'd2, 32'h10, 32'h0);
        enq(1'b1, 3'd1, 32'h22, 32'hCAFE0000);
        enq(1'b0, 3'd1, 32'h22, 32'h0);
        enq(1'b0, 3'd0, 32'h21, 32'h0);
        enq(1'b1, 3'd2, 32'h30, 32'h12345678);
        enq(1'b0, 3'd2, 32'h30, 32'h0);
        enq(1'b1, 3'd0, 32'h30, 32'h000000AA);
        enq(1'b0, 3'd1, 32'h30, 32'h0);
        run(200, n);
        chk("b2b_cycles", 32'(n), 32'(tot + 2));
        chk("b2b_mem17", 32'(mem[17]), 32'hCAFE);

        // Reset during the first strobe of a word write
        n0 = n_we;
        @(posedge clk);
        #1 htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h2000_0040;
        @(posedge clk);
        #1 htrans = 2'b00; hwdata = 32'h13579BDF;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            tick();
            if (!sram_we_n) seen = 1'b1;
            n++;
        end
        chk("rst_reach_strobe", 32'(seen), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_pins", 32'({sram_we_n, sram_ce_n, sram_dq_oe, hready_resp}), 32'hD);
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_idle", 32'({hready_resp, sram_ce_n, sram_we_n, sram_dq_oe}), 32'hE);
        end
        chk("no_second_strobe", 32'(n_we - n0), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
